vram_fetch_arbiter: RTL
=======================

# vram_fetch_arbiter

Arbitrates the PPU's single VRAM read port between the background fetcher and the sprite fetcher. Sprite requests win, and the background fetcher is frozen while a sprite is detected. Each grant is held until its data returns, then the data is routed back to the owning requester. The block sits between the pixel-FIFO fetchers and the VRAM read interface and generates the `mem_free` indication the sprite path consumes.

## Interface
- `TIMEOUT`, default 15: max `clk_in` cycles a grant waits for `vram_data_valid_in` before abort.
- `clk_in` in 1: system clock.
- `rst_in` in 1: synchronous, active-high reset.
- `tclk_in` in 1: T-cycle enable; new grants are issued only in cycles where it is high.
- `bg_addr_in` in 16: background fetcher request address.
- `bg_req_in` in 1: background request valid; held until served.
- `spr_addr_in` in 16: sprite fetcher request address.
- `spr_req_in` in 1: sprite request valid; held until served.
- `sprite_detected_in` in 1: sprite hit on the current X; blocks new background grants.
- `mem_free_out` out 1: high when no background transaction is outstanding and none can start this cycle.
- `vram_addr_out` out 16: address to VRAM.
- `vram_req_out` out 1: single-cycle request strobe to VRAM.
- `vram_data_in` in 8: VRAM read data.
- `vram_data_valid_in` in 1: VRAM read data valid.
- `bg_data_out` out 8: data returned to the background fetcher.
- `bg_valid_out` out 1: one-cycle strobe for `bg_data_out`.
- `spr_data_out` out 8: data returned to the sprite fetcher.
- `spr_valid_out` out 1: one-cycle strobe for `spr_data_out`.
- `timeout_err_out` out 1: sticky; set on any aborted grant, cleared only by reset.

## Operation
- States: IDLE, BG_WAIT, SPR_WAIT.
- IDLE, `tclk_in` high:
  - `spr_req_in` set: go to SPR_WAIT.
  - Otherwise, `bg_req_in` set and `sprite_detected_in` low: go to BG_WAIT.
  - Otherwise: stay in IDLE.
  - On either grant: register the address into `vram_addr_out` and pulse `vram_req_out` for one cycle.
- IDLE, `tclk_in` low: no grant; requests are ignored.
- Simultaneous requests: sprite wins. The background request stays pending and is served after the sprite returns, provided `sprite_detected_in` has dropped.
- BG_WAIT / SPR_WAIT on `vram_data_valid_in`:
  - Register `vram_data_in` into the owner's data output and pulse the owner's valid.
  - Return to IDLE.
  - `vram_data_valid_in` in IDLE is ignored; no output pulses.
- Timeout counter:
  - 4 bits, cleared on every grant, increments each `clk_in` cycle in a WAIT state.
  - When it reaches `TIMEOUT` without valid data: return to IDLE, set `timeout_err_out`, no data pulse.
- A request seen in the same cycle its previous data is returned is not re-granted until the next eligible `tclk_in` cycle from IDLE.
- `mem_free_out` is low in BG_WAIT, and low in IDLE when `sprite_detected_in` is low and `bg_req_in` is high. Otherwise it is high.
- `sprite_detected_in` rising during BG_WAIT does not abort the background transaction. The sprite is granted after it completes.
- Reset mid-transaction discards the outstanding grant. A late `vram_data_valid_in` after reset is dropped, because the block is then in IDLE.

## Timing
- Reset values:
  - State IDLE.
  - `vram_req_out`, `bg_valid_out`, `spr_valid_out` = 0.
  - `vram_addr_out`, `bg_data_out`, `spr_data_out` = 0.
  - `timeout_err_out` = 0.
  - `mem_free_out` = 1.
- Grant latency: request sampled at edge N with `tclk_in` high; `vram_req_out` and `vram_addr_out` are valid in cycle N+1.
- Return latency: `vram_data_valid_in` at edge M; owner's valid and data are valid in cycle M+1.
- Minimum request-to-data for a 1-cycle VRAM: 3 `clk_in` cycles.
- `vram_addr_out` holds its value until the next grant.
- All outputs are registered except `mem_free_out`, which is combinational from state, `bg_req_in` and `sprite_detected_in`.

## Structure
- Shared PPU package:
  - enum `vram_owner_t` {OWNER_NONE, OWNER_BG, OWNER_SPR}, reused as the state type.
  - constants `VRAM_ADDR_W = 16` and `VRAM_DATA_W = 8`.
- One sub-module, `grant_timer`: a loadable up-counter with clear, enable, and terminal-count output, parameterised by `TIMEOUT`.

## Test plan
- Background only: `bg_addr_in`=0x8010, VRAM returns 0x5A one cycle after the strobe -> `vram_addr_out`=0x8010, then `bg_valid_out` pulse with 0x5A; `spr_valid_out` stays 0.
- Both request in the same `tclk_in` cycle (bg 0x8000, spr 0x8100) -> sprite served first with 0xC3, then background with 0x3C.
- `sprite_detected_in` high with only `bg_req_in` -> no grant and `mem_free_out`=1. Drop `sprite_detected_in` -> background granted on the next `tclk_in` cycle.
- `tclk_in` low for 3 cycles with requests pending -> `vram_req_out` stays 0; grant occurs on the first `tclk_in` high cycle.
- VRAM never responds -> after 15 cycles return to IDLE with `timeout_err_out`=1, no data pulse; a following request is served normally and the error flag stays set.
- Reset asserted in SPR_WAIT, then `vram_data_valid_in` arrives -> no `spr_valid_out` pulse, all outputs at reset values.

Source files
------------

// File: rtl/vram_fetch_arbiter_pkg.sv
// Shared PPU VRAM types: ownership/state encoding and bus widths.
package vram_fetch_arbiter_pkg;

    localparam int unsigned VRAM_ADDR_W = 16;
    localparam int unsigned VRAM_DATA_W = 8;
    localparam int unsigned TIMER_W     = 4;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_BG   = 2'd1,
        OWNER_SPR  = 2'd2
    } vram_owner_t;

endpackage

// File: rtl/vram_fetch_arbiter_grant_timer.sv
// Loadable up-counter with clear and enable; tc_out flags the cycle whose edge reaches TIMEOUT.
module vram_fetch_arbiter_grant_timer
    import vram_fetch_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               clr_in,
    input  logic               load_in,
    input  logic [TIMER_W-1:0] load_val_in,
    input  logic               en_in,
    output logic               tc_out
);

    localparam logic [TIMER_W-1:0] TcVal = TIMER_W'(TIMEOUT - 1);

    logic [TIMER_W-1:0] count_q;

    always_ff @(posedge clk_in) begin
        if (rst_in || clr_in) begin
            count_q <= '0;
        end else if (load_in) begin
            count_q <= load_val_in;
        end else if (en_in) begin
            count_q <= count_q + 1'b1;
        end
    end

    // Asserted while the upcoming increment would land on TIMEOUT.
    assign tc_out = en_in && (count_q == TcVal);

endmodule

// File: rtl/vram_fetch_arbiter.sv
// Arbitrates the single VRAM read port between background and sprite fetchers (sprite wins),
// holding each grant until data returns or the grant timer expires.
module vram_fetch_arbiter
    import vram_fetch_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   tclk_in,
    input  logic [VRAM_ADDR_W-1:0] bg_addr_in,
    input  logic                   bg_req_in,
    input  logic [VRAM_ADDR_W-1:0] spr_addr_in,
    input  logic                   spr_req_in,
    input  logic                   sprite_detected_in,
    output logic                   mem_free_out,
    output logic [VRAM_ADDR_W-1:0] vram_addr_out,
    output logic                   vram_req_out,
    input  logic [VRAM_DATA_W-1:0] vram_data_in,
    input  logic                   vram_data_valid_in,
    output logic [VRAM_DATA_W-1:0] bg_data_out,
    output logic                   bg_valid_out,
    output logic [VRAM_DATA_W-1:0] spr_data_out,
    output logic                   spr_valid_out,
    output logic                   timeout_err_out
);

    vram_owner_t state_q;
    logic        idle;
    logic        grant_spr;
    logic        grant_bg;
    logic        timer_tc;

    assign idle      = (state_q == OWNER_NONE);
    assign grant_spr = idle && tclk_in && spr_req_in;
    assign grant_bg  = idle && tclk_in && !spr_req_in && bg_req_in && !sprite_detected_in;

    // Low while a background fetch is outstanding or could be started.
    assign mem_free_out = !((state_q == OWNER_BG) || (idle && bg_req_in && !sprite_detected_in));

    vram_fetch_arbiter_grant_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_grant_timer (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .clr_in      (grant_spr || grant_bg),
        .load_in     (1'b0),
        .load_val_in ('0),
        .en_in       (!idle),
        .tc_out      (timer_tc)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q         <= OWNER_NONE;
            vram_addr_out   <= '0;
            vram_req_out    <= 1'b0;
            bg_data_out     <= '0;
            bg_valid_out    <= 1'b0;
            spr_data_out    <= '0;
            spr_valid_out   <= 1'b0;
            timeout_err_out <= 1'b0;
        end else begin
            vram_req_out  <= 1'b0;
            bg_valid_out  <= 1'b0;
            spr_valid_out <= 1'b0;
            case (state_q)
                OWNER_NONE: begin
                    if (grant_spr) begin
                        state_q       <= OWNER_SPR;
                        vram_addr_out <= spr_addr_in;
                        vram_req_out  <= 1'b1;
                    end else if (grant_bg) begin
                        state_q       <= OWNER_BG;
                        vram_addr_out <= bg_addr_in;
                        vram_req_out  <= 1'b1;
                    end
                end
                OWNER_BG, OWNER_SPR: begin
                    // Data arriving on the expiry edge still counts as a return.
                    if (vram_data_valid_in) begin
                        state_q <= OWNER_NONE;
                        if (state_q == OWNER_SPR) begin
                            spr_data_out  <= vram_data_in;
                            spr_valid_out <= 1'b1;
                        end else begin
                            bg_data_out  <= vram_data_in;
                            bg_valid_out <= 1'b1;
                        end
                    end else if (timer_tc) begin
                        state_q         <= OWNER_NONE;
                        timeout_err_out <= 1'b1;
                    end
                end
                default: state_q <= OWNER_NONE;
            endcase
        end
    end

endmodule
